// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the execute stage and muldiv_seq.
// master = control unit side, slave = sequencer side.
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic             flush;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             dbz;

    modport master (
        output start, op, flush, a, b,
        input  busy, done, hi, lo, dbz
    );

    modport slave (
        input  start, op, flush, a, b,
        output busy, done, hi, lo, dbz
    );
endinterface

// File: rtl/muldiv_seq.sv
// Multi-cycle 32-bit multiply (shift/add) and divide (non-restoring).
// Optional signed support is compiled in with `define MULDIV_SIGNED_EN.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    muldiv_seq_if.slave bus
);
    localparam int W = WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state_q, state_d;
    logic [4:0]     cnt_q;
    logic [2*W:0]   acc_q;
    logic [W-1:0]   opb_q;
    logic [W-1:0]   hi_q, lo_q;
    logic           is_div_q, pend_q, dbz_q;

    logic           dbz_start;
    logic [W-1:0]   mag_a, mag_b;
    logic [W:0]     mul_sum, div_sh, div_nr;
    logic [2*W:0]   mul_nxt, div_nxt, step_nxt;
    logic [W-1:0]   rem_fix, res_hi, res_lo;

`ifdef MULDIV_SIGNED_EN
    logic sa, sb, neg_q, rneg_q;

    assign sa    = bus.op[1] & bus.a[W-1];
    assign sb    = bus.op[1] & bus.b[W-1];
    assign mag_a = sa ? -bus.a : bus.a;
    assign mag_b = sb ? -bus.b : bus.b;
`else
    assign mag_a = bus.a;
    assign mag_b = bus.b;
`endif

    assign dbz_start = bus.op[0] && (bus.b == '0);

    // One iteration of either loop; acc holds {partial,mplier} or {rem,quot}.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*W-1:W]}
                 + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_nxt  = {1'b0, mul_sum, acc_q[W-1:1]};
        div_sh   = {acc_q[2*W-1:W], acc_q[W-1]};
        div_nr   = acc_q[2*W] ? div_sh + {1'b0, opb_q}
                              : div_sh - {1'b0, opb_q};
        div_nxt  = {div_nr, acc_q[W-2:0], ~div_nr[W]};
        rem_fix  = div_nr[W] ? div_nr[W-1:0] + opb_q : div_nr[W-1:0];
        step_nxt = is_div_q ? div_nxt : mul_nxt;
    end

    // Final result taken from the last step, with remainder fix-up and sign.
    always_comb begin
        res_hi = mul_nxt[2*W-1:W];
        res_lo = mul_nxt[W-1:0];
        if (is_div_q) begin
            res_hi = rem_fix;
            res_lo = div_nxt[W-1:0];
        end
`ifdef MULDIV_SIGNED_EN
        if (is_div_q) begin
            if (neg_q)  res_lo = -div_nxt[W-1:0];
            if (rneg_q) res_hi = -rem_fix;
        end else if (neg_q) begin
            {res_hi, res_lo} = -mul_nxt[2*W-1:0];
        end
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state; a divide by zero parks in DONE one extra cycle (pend).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (bus.start) state_d = dbz_start ? DONE : CALC;
            CALC: if (cnt_q == 5'd31) state_d = DONE;
            DONE: if (!pend_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.flush) state_d = IDLE;
    end

    // Operand capture, iteration and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            pend_q   <= 1'b0;
            dbz_q    <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
`endif
        end else if (bus.flush) begin
            pend_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (bus.start) begin
                    cnt_q    <= '0;
                    is_div_q <= bus.op[0];
                    opb_q    <= mag_b;
                    acc_q    <= {{(W+1){1'b0}}, dbz_start ? bus.a : mag_a};
                    pend_q   <= dbz_start;
`ifdef MULDIV_SIGNED_EN
                    neg_q    <= sa ^ sb;
                    rneg_q   <= sa;
`endif
                end
                CALC: begin
                    cnt_q <= cnt_q + 5'd1;
                    acc_q <= step_nxt;
                    if (cnt_q == 5'd31) begin
                        hi_q  <= res_hi;
                        lo_q  <= res_lo;
                        dbz_q <= 1'b0;
                    end
                end
                DONE: if (pend_q) begin
                    pend_q <= 1'b0;
                    hi_q   <= acc_q[W-1:0];
                    lo_q   <= '1;
                    dbz_q  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == DONE) && !pend_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.dbz  = dbz_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed scenarios plus random ops vs. an
// arithmetic reference model.
module tb_muldiv_seq;
    logic clk = 1'b0;
    logic rst_n;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    muldiv_seq_if bus ();

    muldiv_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    function automatic void model(input logic [1:0] o,
                                  input logic [31:0] x, y,
                                  output logic [31:0] eh, el,
                                  output logic ez);
        logic [63:0] p;
        longint      sx, sy;
        logic        sg;
`ifdef MULDIV_SIGNED_EN
        sg = o[1];
`else
        sg = 1'b0;
`endif
        ez = 1'b0;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (o[0] && y == 32'd0) begin
            eh = x;
            el = 32'hFFFF_FFFF;
            ez = 1'b1;
        end else if (!o[0]) begin
            if (sg) p = 64'(sx * sy);
            else    p = 64'(x) * 64'(y);
            eh = p[63:32];
            el = p[31:0];
        end else if (sg) begin
            el = 32'(sx / sy);
            eh = 32'(sx % sy);
        end else begin
            el = x / y;
            eh = x % y;
        end
    endfunction

    // Issue one op from IDLE (#1 after an edge); returns results, the
    // number of edges after E0 until done, and state one edge later.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, y,
                          output logic [31:0] rh, rl, output logic rz,
                          output int lat, output logic pd, pb);
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        rh = bus.hi;
        rl = bus.lo;
        rz = bus.dbz;
        @(posedge clk); #1;
        pd = bus.done;
        pb = bus.busy;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if ({bus.busy, bus.done, bus.dbz} !== 3'b000)
            $display("FAIL reset_ctrl: got %b want 000",
                     {bus.busy, bus.done, bus.dbz});
        else pass_cnt++;
        total_cnt++;
        if ({bus.hi, bus.lo} !== 64'd0)
            $display("FAIL reset_data: got %h want 0", {bus.hi, bus.lo});
        else pass_cnt++;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mul_max();
        logic [31:0] rh, rl;
        logic rz, pd, pb;
        int lat;
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, rh, rl, rz, lat, pd, pb);
        total_cnt++;
        if (lat !== 32) $display("FAIL mul_max lat: got %0d want 32", lat);
        else pass_cnt++;
        total_cnt++;
        if ({rh, rl, rz} !== {64'hFFFF_FFFE_0000_0001, 1'b0})
            $display("FAIL mul_max res: got %h_%h dbz %b want fffffffe_00000001 dbz 0",
                     rh, rl, rz);
        else pass_cnt++;
        total_cnt++;
        if ({pd, pb} !== 2'b00)
            $display("FAIL mul_max post: got done,busy %b want 00", {pd, pb});
        else pass_cnt++;
    endtask

    task automatic test_div_basic();
        logic [31:0] rh, rl;
        logic rz, pd, pb;
        int lat;
        run_op(2'b01, 32'd100, 32'd7, rh, rl, rz, lat, pd, pb);
        total_cnt++;
        if ({lat, rh, rl, rz} !== {32'd32, 32'd2, 32'd14, 1'b0})
            $display("FAIL div_100_7: got lat %0d hi %0d lo %0d dbz %b want 32 2 14 0",
                     lat, rh, rl, rz);
        else pass_cnt++;
        run_op(2'b01, 32'hFFFF_FFFF, 32'd1, rh, rl, rz, lat, pd, pb);
        total_cnt++;
        if ({lat, rh, rl} !== {32'd32, 32'd0, 32'hFFFF_FFFF})
            $display("FAIL div_max_1: got lat %0d hi %h lo %h want 32 0 ffffffff",
                     lat, rh, rl);
        else pass_cnt++;
    endtask

    task automatic test_dbz();
        logic [31:0] rh, rl;
        logic rz, pd, pb;
        int lat;
        run_op(2'b01, 32'd5, 32'd0, rh, rl, rz, lat, pd, pb);
        total_cnt++;
        if (lat !== 1) $display("FAIL dbz lat: got %0d want 1", lat);
        else pass_cnt++;
        total_cnt++;
        if ({rh, rl, rz} !== {32'd5, 32'hFFFF_FFFF, 1'b1})
            $display("FAIL dbz res: got hi %h lo %h dbz %b want 5 ffffffff 1",
                     rh, rl, rz);
        else pass_cnt++;
        total_cnt++;
        if ({pd, pb} !== 2'b00)
            $display("FAIL dbz post: got done,busy %b want 00", {pd, pb});
        else pass_cnt++;
    endtask

    task automatic test_ignore_start();
        logic [31:0] rh, rl;
        logic rz, pd, pb;
        int k, lat;
        bus.op    = 2'b00;
        bus.a     = 32'd3;
        bus.b     = 32'd4;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        bus.a     = 32'd9;
        bus.b     = 32'd9;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        k = 10;
        while (bus.done !== 1'b1 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        total_cnt++;
        if ({k, bus.hi, bus.lo} !== {32'd32, 32'd0, 32'd12})
            $display("FAIL ignore_start: got lat %0d hi %0d lo %0d want 32 0 12",
                     k, bus.hi, bus.lo);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (bus.busy !== 1'b0)
            $display("FAIL ignore_idle: got busy %b want 0", bus.busy);
        else pass_cnt++;
        run_op(2'b00, 32'd9, 32'd9, rh, rl, rz, lat, pd, pb);
        total_cnt++;
        if ({lat, rl} !== {32'd32, 32'd81})
            $display("FAIL restart: got lat %0d lo %0d want 32 81", lat, rl);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        logic [31:0] ph, pl;
        logic seen;
        ph = bus.hi;
        pl = bus.lo;
        bus.op    = 2'b00;
        bus.a     = $urandom | 32'h1;
        bus.b     = $urandom | 32'h1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        total_cnt++;
        if ({bus.busy, bus.done} !== 2'b00)
            $display("FAIL flush_idle: got busy,done %b want 00",
                     {bus.busy, bus.done});
        else pass_cnt++;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen = 1'b1;
        end
        total_cnt++;
        if (seen !== 1'b0) $display("FAIL flush_quiet: got activity 1 want 0");
        else pass_cnt++;
        total_cnt++;
        if ({bus.hi, bus.lo} !== {ph, pl})
            $display("FAIL flush_hold: got %h_%h want %h_%h",
                     bus.hi, bus.lo, ph, pl);
        else pass_cnt++;
        bus.a     = 32'd6;
        bus.b     = 32'd7;
        bus.start = 1'b1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        total_cnt++;
        if (bus.busy !== 1'b0)
            $display("FAIL flush_start: got busy %b want 0", bus.busy);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        bus.op    = 2'b01;
        bus.a     = $urandom;
        bus.b     = $urandom | 32'h1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (12) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({bus.busy, bus.done, bus.dbz, bus.hi, bus.lo} !== 67'd0)
            $display("FAIL reset_mid: got busy %b done %b dbz %b hi %h lo %h want all 0",
                     bus.busy, bus.done, bus.dbz, bus.hi, bus.lo);
        else pass_cnt++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [31:0] x, y, rh, rl, eh, el;
        logic [1:0] o;
        logic rz, ez, pd, pb;
        int lat, el_lat;
        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            y = $urandom;
            if ($urandom_range(0, 3) == 0) y = $urandom_range(1, 15);
            if ($urandom_range(0, 5) == 0) y = 32'd0;
            model(o, x, y, eh, el, ez);
            el_lat = (o[0] && y == 32'd0) ? 1 : 32;
            run_op(o, x, y, rh, rl, rz, lat, pd, pb);
            total_cnt++;
            if ({rh, rl, rz} !== {eh, el, ez} || lat != el_lat)
                $display("FAIL rand[%0d] op %b a %h b %h: got %h_%h dbz %b lat %0d want %h_%h dbz %b lat %0d",
                         i, o, x, y, rh, rl, rz, lat, eh, el, ez, el_lat);
            else pass_cnt++;
            total_cnt++;
            if ({pd, pb} !== 2'b00)
                $display("FAIL rand_post[%0d]: got done,busy %b want 00", i, {pd, pb});
            else pass_cnt++;
        end
    endtask

`ifdef MULDIV_SIGNED_EN
    task automatic test_signed();
        logic [31:0] rh, rl;
        logic rz, pd, pb;
        int lat;
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, rh, rl, rz, lat, pd, pb);
        total_cnt++;
        if ({lat, rh, rl} !== {32'd32, 32'hFFFF_FFFF, 32'hFFFF_FFFD})
            $display("FAIL sdiv_m7_2: got lat %0d hi %h lo %h want 32 ffffffff fffffffd",
                     lat, rh, rl);
        else pass_cnt++;
        run_op(2'b10, 32'hFFFF_FFFD, 32'd5, rh, rl, rz, lat, pd, pb);
        total_cnt++;
        if ({lat, rh, rl} !== {32'd32, 32'hFFFF_FFFF, 32'hFFFF_FFF1})
            $display("FAIL smul_m3_5: got lat %0d hi %h lo %h want 32 ffffffff fffffff1",
                     lat, rh, rl);
        else pass_cnt++;
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, rh, rl, rz, lat, pd, pb);
        total_cnt++;
        if ({rh, rl} !== {32'd0, 32'h8000_0000})
            $display("FAIL sdiv_ovf: got hi %h lo %h want 0 80000000", rh, rl);
        else pass_cnt++;
        run_op(2'b11, 32'hFFFF_FFF7, 32'd0, rh, rl, rz, lat, pd, pb);
        total_cnt++;
        if ({lat, rh, rl, rz} !== {32'd1, 32'hFFFF_FFF7, 32'hFFFF_FFFF, 1'b1})
            $display("FAIL sdiv_zero: got lat %0d hi %h lo %h dbz %b want 1 fffffff7 ffffffff 1",
                     lat, rh, rl, rz);
        else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_mul_max();
        test_div_basic();
        test_dbz();
        test_ignore_start();
        test_flush();
        test_reset_mid();
        test_random();
`ifdef MULDIV_SIGNED_EN
        test_signed();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
